pipeline_elastic: RTL and testbench

Parametrised successor to the fixed 8-bit, two-output `pipeline` block. It is a DEPTH-stage, two-lane (A, B) elastic pipeline with valid/ready handshakes on input and output, per-stage bubble collapse, synchronous flush and an occupancy counter. Lane A passes through unchanged. Lane B accumulates lane A once per stage. It sits between a producer and a consumer that may each stall independently.

---
 rtl/pipeline_elastic_if.sv | 27 ++
 rtl/pipeline_elastic.sv | 86 ++++++++
 tb/tb_pipeline_elastic.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_elastic_if.sv
// pipeline_elastic handshake bundle
// producer/consumer side is master, pipeline is slave
interface pipeline_elastic_if #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [CNTW-1:0]  occupancy;

   modport master (
      output in_valid, in_a, in_b, flush, out_ready,
      input  in_ready, out_valid, A, B, occupancy
   );

   modport slave (
      input  in_valid, in_a, in_b, flush, out_ready,
      output in_ready, out_valid, A, B, occupancy
   );
endinterface

// File: rtl/pipeline_elastic.sv
// pipeline_elastic: DEPTH-stage two-lane elastic pipeline
// lane A passes through, lane B adds lane A at every stage
module pipeline_elastic #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNTW  = 5
) (
   input logic          clk,
   input logic          rst_n,
   pipeline_elastic_if.slave bus
);
   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] rdy;
   logic [WIDTH-1:0] a_q [DEPTH];
   logic [WIDTH-1:0] b_q [DEPTH];
   logic [CNTW-1:0]  occ;
   logic             acc;
   logic             xfer;

   // ready ripples up from the output so any bubble lets upstream advance
   always_comb begin
      rdy = '0;
      rdy[DEPTH-1] = !v[DEPTH-1] | bus.out_ready;
      for (int k = DEPTH - 2; k >= 0; k--) begin
         rdy[k] = !v[k] | rdy[k+1];
      end
   end

   assign acc           = bus.in_valid & rdy[0];
   assign xfer          = v[DEPTH-1] & bus.out_ready;
   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = v[DEPTH-1];
   assign bus.A         = a_q[DEPTH-1];
   assign bus.B         = b_q[DEPTH-1];
   assign bus.occupancy = occ;

   // valid bits move with ready; flush empties every stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
      end else if (bus.flush) begin
         v <= '0;
      end else begin
         if (rdy[0]) v[0] <= bus.in_valid;
         for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) v[k] <= v[k-1];
         end
      end
   end

   // data loads only with a real item so outputs hold when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
      end else begin
         if (acc) begin
            a_q[0] <= bus.in_a;
            b_q[0] <= bus.in_b + bus.in_a;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k] && v[k-1]) begin
               a_q[k] <= a_q[k-1];
               b_q[k] <= b_q[k-1] + a_q[k-1];
            end
         end
      end
   end

   // occupancy tracks accepts minus output transfers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ <= '0;
      end else if (bus.flush) begin
         occ <= '0;
      end else begin
         unique case ({acc, xfer})
            2'b10:   occ <= occ + CNTW'(1);
            2'b01:   occ <= occ - CNTW'(1);
            default: occ <= occ;
         endcase
      end
   end
endmodule

// File: tb/tb_pipeline_elastic.sv
// tb_pipeline_elastic: scoreboard bench for pipeline_elastic
// directed main instance plus DEPTH=1 / DEPTH=16 random sweeps
module tb_pipeline_elastic;
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      int         cyc;
      bit         lat;
   } exp_t;

   logic     clk = 0;
   logic     rst_n;
   int       total = 0;
   int       bad = 0;
   int       cyc = 0;
   bit       sweep_go;
   bit [1:0] sweep_done;
   exp_t     sb[$];
   exp_t     e;

   pipeline_elastic_if #(.WIDTH(8), .CNTW(5)) bus();

   pipeline_elastic #(.WIDTH(8), .DEPTH(4), .CNTW(5)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ea, input logic [7:0] eb,
                       input bit lat);
      bit got;
      got = 0;
      bus.in_valid = 1;
      bus.in_a = a;
      bus.in_b = b;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back('{ea, eb, cyc + 4, lat});
            got = 1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      if (!got) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      chk("drain_left", sb.size(), 0);
   endtask

   // main scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.flush) begin
            sb.delete();
         end else if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("out_A", bus.A, e.a);
               chk("out_B", bus.B, e.b);
               if (e.lat) chk("latency", cyc, e.cyc);
            end
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : sw
      localparam int D = (g == 0) ? 1 : 16;
      localparam int W = (g == 0) ? 4 : 16;
      pipeline_elastic_if #(.WIDTH(W), .CNTW(5)) sbus();
      pipeline_elastic #(.WIDTH(W), .DEPTH(D), .CNTW(5)) dut (
         .clk(clk),
         .rst_n(rst_n),
         .bus(sbus.slave)
      );
      logic [2*W-1:0] q[$];
      logic [2*W-1:0] se;
      logic [W-1:0]   eb;
      int             acc_n;

      // sweep monitor
      always @(negedge clk) begin
         if (rst_n && sweep_go) begin
            if (sbus.out_valid && sbus.out_ready) begin
               if (q.size() == 0) begin
                  chk("sw_unexpected", 1, 0);
               end else begin
                  se = q.pop_front();
                  chk("sw_A", sbus.A, se[2*W-1:W]);
                  chk("sw_B", sbus.B, se[W-1:0]);
               end
            end
            chk("sw_occ_max", int'(sbus.occupancy) > D, 0);
         end
      end

      initial begin
         sbus.in_valid = 0;
         sbus.in_a = '0;
         sbus.in_b = '0;
         sbus.flush = 0;
         sbus.out_ready = 0;
         acc_n = 0;
         wait (sweep_go);
         @(posedge clk);
         for (int c = 0; c < 3000 && acc_n < 150; c++) begin
            #1;
            sbus.in_valid = 1'($urandom_range(0, 1));
            sbus.in_a = W'($urandom);
            sbus.in_b = W'($urandom);
            sbus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (sbus.in_valid && sbus.in_ready) begin
               eb = sbus.in_b + W'(D) * sbus.in_a;
               q.push_back({sbus.in_a, eb});
               acc_n++;
            end
            @(posedge clk);
         end
         #1;
         sbus.in_valid = 0;
         sbus.out_ready = 1;
         for (int c = 0; c < 100 && q.size() != 0; c++) @(negedge clk);
         chk("sw_drain_left", q.size(), 0);
         sweep_done[g] = 1;
      end
   end

   initial begin
      rst_n = 0;
      bus.in_valid = 0;
      bus.in_a = 0;
      bus.in_b = 0;
      bus.flush = 0;
      bus.out_ready = 0;
      #12;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_occ", bus.occupancy, 0);
      chk("rst_A", bus.A, 0);
      chk("rst_B", bus.B, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1;

      // streaming
      @(posedge clk);
      #1;
      bus.out_ready = 1;
      send(8'h01, 8'h00, 8'h01, 8'h04, 1);
      send(8'h02, 8'h05, 8'h02, 8'h0D, 1);
      send(8'h03, 8'hFF, 8'h03, 8'h0B, 1);
      drain();

      // backpressure
      @(posedge clk);
      #1;
      bus.out_ready = 0;
      send(8'h04, 8'h01, 8'h04, 8'h11, 0);
      send(8'h05, 8'h02, 8'h05, 8'h16, 0);
      send(8'h40, 8'h10, 8'h40, 8'h10, 0);
      send(8'hFF, 8'h03, 8'hFF, 8'hFF, 0);
      @(negedge clk);
      chk("bp_occ_full", bus.occupancy, 4);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      bus.in_valid = 1;
      bus.in_a = 8'h07;
      bus.in_b = 8'h07;
      repeat (3) begin
         @(negedge clk);
         chk("bp_hold_A", bus.A, 8'h04);
         chk("bp_hold_B", bus.B, 8'h11);
         chk("bp_hold_ready", bus.in_ready, 0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1;
      @(negedge clk);
      chk("bp_release_ready", bus.in_ready, 1);
      chk("bp_release_occ", bus.occupancy, 4);
      sb.push_back('{8'h07, 8'h23, 0, 0});
      @(posedge clk);
      #1;
      bus.in_valid = 0;
      drain();

      // bubble collapse
      @(posedge clk);
      #1;
      bus.out_ready = 0;
      send(8'h09, 8'h01, 8'h09, 8'h25, 0);
      repeat (2) @(posedge clk);
      #1;
      send(8'h0A, 8'h00, 8'h0A, 8'h28, 0);
      repeat (5) @(posedge clk);
      #1;
      @(negedge clk);
      chk("bub_occ", bus.occupancy, 2);
      @(posedge clk);
      #1;
      bus.out_ready = 1;
      @(negedge clk);
      chk("bub_first_v", bus.out_valid, 1);
      chk("bub_first_A", bus.A, 8'h09);
      @(negedge clk);
      chk("bub_second_v", bus.out_valid, 1);
      chk("bub_second_A", bus.A, 8'h0A);
      @(negedge clk);
      chk("bub_empty", bus.out_valid, 0);

      // flush
      @(posedge clk);
      #1;
      bus.out_ready = 0;
      send(8'h01, 8'h01, 8'h01, 8'h05, 0);
      send(8'h02, 8'h02, 8'h02, 8'h0A, 0);
      send(8'h03, 8'h03, 8'h03, 8'h0F, 0);
      @(negedge clk);
      chk("fl_occ3", bus.occupancy, 3);
      @(posedge clk);
      #1;
      bus.flush = 1;
      bus.in_valid = 1;
      bus.in_a = 8'h55;
      bus.in_b = 8'h55;
      @(negedge clk);
      chk("fl_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.flush = 0;
      bus.in_valid = 0;
      @(negedge clk);
      chk("fl_occ0", bus.occupancy, 0);
      chk("fl_out_valid", bus.out_valid, 0);
      @(posedge clk);
      #1;
      bus.out_ready = 1;
      repeat (8) @(negedge clk);
      chk("fl_no_output", bus.out_valid, 0);
      @(posedge clk);
      #1;
      send(8'h06, 8'h00, 8'h06, 8'h18, 1);
      drain();

      // asynchronous reset mid-stream
      @(posedge clk);
      #1;
      bus.out_ready = 0;
      send(8'h11, 8'h22, 8'h11, 8'h66, 0);
      send(8'h12, 8'h01, 8'h12, 8'h49, 0);
      @(posedge clk);
      #3;
      rst_n = 0;
      #1;
      chk("mr_out_valid", bus.out_valid, 0);
      chk("mr_occ", bus.occupancy, 0);
      chk("mr_A", bus.A, 0);
      chk("mr_B", bus.B, 0);
      chk("mr_in_ready", bus.in_ready, 1);
      sb.delete();
      #19;
      rst_n = 1;
      @(posedge clk);
      #1;
      bus.out_ready = 1;
      send(8'h01, 8'h00, 8'h01, 8'h04, 1);
      drain();

      // parameter sweep
      sweep_go = 1;
      for (int i = 0; i < 20000 && sweep_done != 2'b11; i++) @(posedge clk);
      chk("sweep_finished", sweep_done, 2'b11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
